// File: rtl/mod_check_pkg.sv
// Shared state encoding, default sizes and width helpers for the mod-N check scheduler.
package mod_check_pkg;

  localparam int unsigned DEF_NUM_REQ = 2;
  localparam int unsigned DEF_WORD_W  = 8;
  localparam int unsigned DEF_DIVISOR = 5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } state_t;

  // Bits needed to encode n distinct values; never below one so ports stay legal.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Bits needed to hold a count that runs from n down to 0.
  function automatic int unsigned cnt_w(input int unsigned n);
    return idx_w(n + 1);
  endfunction

endpackage

// File: rtl/mod_n_residue.sv
// Serial residue engine: each enabled cycle folds one MSB-first bit into r = (2r + b) mod DIVISOR.
module mod_n_residue import mod_check_pkg::*; #(
  parameter  int unsigned DIVISOR = DEF_DIVISOR,
  localparam int unsigned RES_W   = idx_w(DIVISOR)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  output logic [RES_W-1:0] residue
);

  localparam int unsigned    EXT_W = RES_W + 1;
  localparam logic [RES_W:0] MOD   = EXT_W'(DIVISOR);

  logic [RES_W-1:0] residue_q, residue_d;
  logic [RES_W:0]   doubled;

  // 2r+b never reaches 2*DIVISOR, so a single conditional subtract fully reduces it.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    doubled   = {residue_q, bit_in};
    residue_d = residue_q;
    if (clr) begin
      residue_d = '0;
    end else if (en) begin
      residue_d = (doubled >= MOD) ? RES_W'(doubled - MOD) : doubled[RES_W-1:0];
    end
  end

  // NOTE: state updates use non-blocking assignment so all flops sample the same edge.
  always_ff @(posedge clk) begin
    if (rst) residue_q <= '0;
    else     residue_q <= residue_d;
  end

  assign residue = residue_q;

endmodule

// File: rtl/mod_check_scheduler.sv
// Round-robin front end sharing one serial mod-DIVISOR residue engine among NUM_REQ requesters.
// Optional abort input enabled by defining MOD_CHECK_ABORT_EN.
module mod_check_scheduler import mod_check_pkg::*; #(
  parameter  int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter  int unsigned WORD_W  = DEF_WORD_W,
  parameter  int unsigned DIVISOR = DEF_DIVISOR,
  localparam int unsigned RES_W   = idx_w(DIVISOR),
  localparam int unsigned ID_W    = idx_w(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
`ifdef MOD_CHECK_ABORT_EN
  input  logic                      abort,
`endif
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*WORD_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      busy,
  output logic                      res_valid,
  output logic                      res_divisible,
  output logic [RES_W-1:0]          res_residue,
  output logic [ID_W-1:0]           res_id
);

  localparam int unsigned CNT_W = cnt_w(WORD_W);
  localparam int unsigned EXT_W = ID_W + 1;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;
  logic [RES_W-1:0]  held_res_q, held_res_d;
  logic [ID_W-1:0]   held_id_q, held_id_d;
  logic              held_div_q, held_div_d;

  logic [ID_W-1:0]   winner;
  logic              found;
  logic              handshake;
  logic              abort_req;
  logic [WORD_W-1:0] sel_word;
  logic [RES_W-1:0]  residue;

`ifdef MOD_CHECK_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Search starts just after the last grant and wraps, giving round-robin fairness.
  always_comb begin
    logic [ID_W:0] idx;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = {1'b0, last_grant_q} + EXT_W'(i);
      if (idx >= EXT_W'(NUM_REQ)) idx = idx - EXT_W'(NUM_REQ);
      if (!found && req_valid[idx[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_W'(i)) sel_word = req_data[i*WORD_W +: WORD_W];
    end
  end

  assign handshake = (state_q == IDLE) && found;
  assign req_ready = handshake ? (NUM_REQ'(1) << winner) : '0;

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    cnt_d        = cnt_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    held_res_d   = held_res_q;
    held_id_d    = held_id_q;
    held_div_d   = held_div_q;
    case (state_q)
      IDLE: begin
        if (handshake) begin
          shreg_d      = sel_word;
          cnt_d        = CNT_W'(WORD_W);
          id_d         = winner;
          last_grant_d = winner;
          state_d      = SHIFT;
        end
      end
      SHIFT: begin
        shreg_d = shreg_q << 1;
        cnt_d   = cnt_q - CNT_W'(1);
        if (abort_req)                 state_d = IDLE;
        else if (cnt_q == CNT_W'(1))   state_d = DONE;
      end
      DONE: begin
        held_res_d = residue;
        held_id_d  = id_q;
        held_div_d = (residue == '0);
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      id_q         <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      held_res_q   <= '0;
      held_id_q    <= '0;
      held_div_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      held_res_q   <= held_res_d;
      held_id_q    <= held_id_d;
      held_div_q   <= held_div_d;
    end
  end

  mod_n_residue #(.DIVISOR(DIVISOR)) u_residue (
    .clk     (clk),
    .rst     (rst),
    .clr     (handshake),
    .en      (state_q == SHIFT),
    .bit_in  (shreg_q[WORD_W-1]),
    .residue (residue)
  );

  // Live engine values are shown during DONE; the held copies keep them visible afterwards.
  assign busy          = (state_q != IDLE);
  assign res_valid     = (state_q == DONE);
  assign res_residue   = res_valid ? residue : held_res_q;
  assign res_id        = res_valid ? id_q : held_id_q;
  assign res_divisible = res_valid ? (residue == '0) : held_div_q;

endmodule

// File: tb/tb_mod_check_scheduler.sv
// Bench for mod_check_scheduler: directed cases plus randomized traffic against a round-robin / modulo model.
// Define MOD_CHECK_ABORT_EN to include the abort scenario.
module tb_mod_check_scheduler;

  localparam int NUM_REQ = 2;
  localparam int WORD_W  = 8;
  localparam int DIVISOR = 5;
  localparam int RES_W   = $clog2(DIVISOR);
  localparam int ID_W    = $clog2(NUM_REQ);
  localparam int BUDGET  = 4 * WORD_W + 8;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
`ifdef MOD_CHECK_ABORT_EN
  logic                      abort = 1'b0;
`endif
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ*WORD_W-1:0] req_data = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      busy;
  logic                      res_valid;
  logic                      res_divisible;
  logic [RES_W-1:0]          res_residue;
  logic [ID_W-1:0]           res_id;

  int          checks       = 0;
  int          failures     = 0;
  int          last_grant_m = NUM_REQ - 1;
  int unsigned cyc          = 0;

  mod_check_scheduler #(.NUM_REQ(NUM_REQ), .WORD_W(WORD_W), .DIVISOR(DIVISOR)) dut (
    .clk           (clk),
    .rst           (rst),
`ifdef MOD_CHECK_ABORT_EN
    .abort         (abort),
`endif
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .busy          (busy),
    .res_valid     (res_valid),
    .res_divisible (res_divisible),
    .res_residue   (res_residue),
    .res_id        (res_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Reference arbitration: first valid requester after the last grant, wrapping around.
  function automatic int rr_pick(input logic [NUM_REQ-1:0] mask, input int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (mask[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input int k);
    logic [NUM_REQ-1:0] v;
    v = '0;
    if (k >= 0) v[k] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int k, input logic [WORD_W-1:0] w);
    req_data[k*WORD_W +: WORD_W] = w;
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    req_valid = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    last_grant_m = NUM_REQ - 1;
  endtask

  // Edges after the handshake edge until res_valid is seen (capped at BUDGET).
  task automatic wait_result(output int lat);
    lat = 0;
    while (res_valid !== 1'b1 && lat < BUDGET) begin
      tick();
      lat++;
    end
  endtask

  // One request/response: raise mask, capture ready, drop valid after the edge, collect the result.
  task automatic transact(input  logic [NUM_REQ-1:0] mask,
                          output logic [NUM_REQ-1:0] rdy,
                          output logic               bsy,
                          output int                 lat,
                          output logic               div,
                          output logic [RES_W-1:0]   res,
                          output logic [ID_W-1:0]    id,
                          output logic               lingering);
    req_valid = mask;
    #1;
    rdy = req_ready;
    tick();
    req_valid = '0;
    #1;
    bsy = busy;
    wait_result(lat);
    div = res_divisible;
    res = res_residue;
    id  = res_id;
    tick();
    lingering = res_valid;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (req_ready !== '0)    begin failures++; $display("FAIL reset_ready: got %b want 0", req_ready); end
    checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (res_valid !== 1'b0)  begin failures++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
    checks++; if (res_divisible !== 1'b0) begin failures++; $display("FAIL reset_divisible: got %b want 0", res_divisible); end
    checks++; if (res_residue !== '0)  begin failures++; $display("FAIL reset_residue: got %0d want 0", res_residue); end
    checks++; if (res_id !== '0)       begin failures++; $display("FAIL reset_id: got %0d want 0", res_id); end
  endtask

  task automatic test_directed();
    int                 dir_req [5] = '{0, 1, 0, 0, 0};
    logic [WORD_W-1:0]  dir_word[5] = '{8'd25, 8'b11001110, 8'hFF, 8'd0, 8'd254};
    int                 dir_res [5] = '{0, 1, 0, 0, 4};
    logic [NUM_REQ-1:0] rdy;
    logic               bsy, div, ling;
    logic [RES_W-1:0]   res;
    logic [ID_W-1:0]    id;
    int                 lat;
    for (int i = 0; i < 5; i++) begin
      set_word(dir_req[i], dir_word[i]);
      transact(onehot(dir_req[i]), rdy, bsy, lat, div, res, id, ling);
      last_grant_m = dir_req[i];
      checks++; if (rdy !== onehot(dir_req[i])) begin failures++; $display("FAIL dir_ready[%0d]: got %b want %b", i, rdy, onehot(dir_req[i])); end
      checks++; if (bsy !== 1'b1) begin failures++; $display("FAIL dir_busy[%0d]: got %b want 1", i, bsy); end
      // res_valid sits in the cycle ending at edge T+WORD_W+1, i.e. first seen WORD_W edges after T.
      checks++; if (lat !== WORD_W) begin failures++; $display("FAIL dir_latency[%0d]: got %0d want %0d", i, lat, WORD_W); end
      checks++; if (res !== RES_W'(dir_res[i])) begin failures++; $display("FAIL dir_residue[%0d]: got %0d want %0d", i, res, dir_res[i]); end
      checks++; if (div !== (dir_res[i] == 0)) begin failures++; $display("FAIL dir_divisible[%0d]: got %b want %b", i, div, dir_res[i] == 0); end
      checks++; if (id !== ID_W'(dir_req[i])) begin failures++; $display("FAIL dir_id[%0d]: got %0d want %0d", i, id, dir_req[i]); end
      checks++; if (ling !== 1'b0) begin failures++; $display("FAIL dir_single_strobe[%0d]: got %b want 0", i, ling); end
    end
    repeat (4) tick();
    checks++; if (res_residue !== RES_W'(4)) begin failures++; $display("FAIL hold_residue: got %0d want 4", res_residue); end
    checks++; if (res_divisible !== 1'b0) begin failures++; $display("FAIL hold_divisible: got %b want 0", res_divisible); end
    checks++; if (res_id !== '0) begin failures++; $display("FAIL hold_id: got %0d want 0", res_id); end
  endtask

  task automatic test_random();
    logic [WORD_W-1:0]  words[NUM_REQ];
    logic [NUM_REQ-1:0] mask, rdy;
    logic               bsy, div, ling;
    logic [RES_W-1:0]   res;
    logic [ID_W-1:0]    id;
    int                 lat, w, sel, exp_res;
    for (int it = 0; it < 24; it++) begin
      mask = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      for (int k = 0; k < NUM_REQ; k++) begin
        sel = $urandom_range(0, 5);
        words[k] = (sel == 0) ? '0 : (sel == 1) ? '1 : WORD_W'($urandom);
        set_word(k, words[k]);
      end
      w       = rr_pick(mask, last_grant_m);
      exp_res = int'(words[w]) % DIVISOR;
      transact(mask, rdy, bsy, lat, div, res, id, ling);
      last_grant_m = w;
      checks++; if (rdy !== onehot(w)) begin failures++; $display("FAIL rnd_ready[%0d]: got %b want %b", it, rdy, onehot(w)); end
      checks++; if (lat !== WORD_W) begin failures++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", it, lat, WORD_W); end
      checks++; if (res !== RES_W'(exp_res)) begin failures++; $display("FAIL rnd_residue[%0d]: word %0d got %0d want %0d", it, words[w], res, exp_res); end
      checks++; if (div !== (exp_res == 0)) begin failures++; $display("FAIL rnd_divisible[%0d]: got %b want %b", it, div, exp_res == 0); end
      checks++; if (id !== ID_W'(w)) begin failures++; $display("FAIL rnd_id[%0d]: got %0d want %0d", it, id, w); end
    end
  endtask

  task automatic test_back_to_back();
    logic [WORD_W-1:0] words[NUM_REQ][4];
    int                sent[NUM_REQ];
    int                exp_id_q[$];
    int                exp_res_q[$];
    int                grants, results, w, e_id, e_res;
    longint            prev_hs;
    apply_reset();
    grants  = 0;
    results = 0;
    prev_hs = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int j = 0; j < 4; j++) words[k][j] = WORD_W'($urandom);
      sent[k] = 0;
      set_word(k, words[k][0]);
    end
    req_valid = '1;
    #1;
    for (int c = 0; c < 200 && results < 4 * NUM_REQ; c++) begin
      if (res_valid === 1'b1) begin
        e_id  = (exp_id_q.size() > 0) ? exp_id_q.pop_front() : -1;
        e_res = (exp_res_q.size() > 0) ? exp_res_q.pop_front() : -1;
        results++;
        checks++; if (int'(res_id) !== e_id) begin failures++; $display("FAIL b2b_id[%0d]: got %0d want %0d", results, res_id, e_id); end
        checks++; if (int'(res_residue) !== e_res) begin failures++; $display("FAIL b2b_residue[%0d]: got %0d want %0d", results, res_residue, e_res); end
        checks++; if (res_divisible !== (e_res == 0)) begin failures++; $display("FAIL b2b_divisible[%0d]: got %b want %b", results, res_divisible, e_res == 0); end
      end
      if (req_ready !== '0) begin
        w = rr_pick(req_valid, last_grant_m);
        checks++; if (req_ready !== onehot(w)) begin failures++; $display("FAIL b2b_grant[%0d]: got %b want %b", grants, req_ready, onehot(w)); end
        if (prev_hs >= 0) begin
          checks++; if (longint'(cyc) - prev_hs !== longint'(WORD_W + 2)) begin failures++; $display("FAIL b2b_spacing[%0d]: got %0d want %0d", grants, longint'(cyc) - prev_hs, WORD_W + 2); end
        end
        prev_hs = longint'(cyc);
        grants++;
        if (w >= 0) begin
          exp_id_q.push_back(w);
          exp_res_q.push_back(int'(words[w][sent[w]]) % DIVISOR);
          last_grant_m = w;
          sent[w]++;
        end
        tick();
        if (w >= 0) begin
          if (sent[w] < 4) set_word(w, words[w][sent[w]]);
          else             req_valid[w] = 1'b0;
        end
        #1;
      end else begin
        tick();
        #1;
      end
    end
    req_valid = '0;
    checks++; if (grants !== 4 * NUM_REQ) begin failures++; $display("FAIL b2b_grant_count: got %0d want %0d", grants, 4 * NUM_REQ); end
    checks++; if (results !== 4 * NUM_REQ) begin failures++; $display("FAIL b2b_result_count: got %0d want %0d", results, 4 * NUM_REQ); end
  endtask

  task automatic test_reset_mid();
    logic [NUM_REQ-1:0] rdy;
    logic               bsy, div, ling, stray;
    logic [RES_W-1:0]   res;
    logic [ID_W-1:0]    id;
    int                 lat;
    apply_reset();
    set_word(0, 8'd7);
    transact(2'b01, rdy, bsy, lat, div, res, id, ling);
    last_grant_m = 0;
    checks++; if (res !== RES_W'(2)) begin failures++; $display("FAIL rstmid_setup_residue: got %0d want 2", res); end
    set_word(1, 8'd201);
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== onehot(rr_pick(req_valid, last_grant_m))) begin failures++; $display("FAIL rstmid_grant1: got %b want %b", req_ready, onehot(rr_pick(req_valid, last_grant_m))); end
    stray = 1'b0;
    tick();
    repeat (2) begin
      tick();
      stray |= res_valid;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    last_grant_m = NUM_REQ - 1;
    #1;
    stray |= res_valid;
    checks++; if (stray !== 1'b0) begin failures++; $display("FAIL rstmid_no_result: got %b want 0", stray); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    checks++; if (res_residue !== '0) begin failures++; $display("FAIL rstmid_residue: got %0d want 0", res_residue); end
    checks++; if (res_id !== '0) begin failures++; $display("FAIL rstmid_id: got %0d want 0", res_id); end
    checks++; if (res_divisible !== 1'b0) begin failures++; $display("FAIL rstmid_divisible: got %b want 0", res_divisible); end
    checks++; if (req_ready !== onehot(rr_pick(req_valid, last_grant_m))) begin failures++; $display("FAIL rstmid_grant_after: got %b want %b", req_ready, onehot(rr_pick(req_valid, last_grant_m))); end
    tick();
    req_valid = '0;
    last_grant_m = 0;
    #1;
    wait_result(lat);
    checks++; if (lat !== WORD_W) begin failures++; $display("FAIL rstmid_latency: got %0d want %0d", lat, WORD_W); end
    checks++; if (res_id !== '0) begin failures++; $display("FAIL rstmid_new_id: got %0d want 0", res_id); end
    checks++; if (res_residue !== RES_W'(2)) begin failures++; $display("FAIL rstmid_new_residue: got %0d want 2", res_residue); end
    tick();
  endtask

`ifdef MOD_CHECK_ABORT_EN
  task automatic test_abort();
    int lat;
    apply_reset();
    set_word(0, 8'd9);
    set_word(1, 8'd13);
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL abort_grant0: got %b want 01", req_ready); end
    tick();
    last_grant_m = 0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b want 0", busy); end
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL abort_res_valid: got %b want 0", res_valid); end
    checks++; if (req_ready !== onehot(rr_pick(req_valid, last_grant_m))) begin failures++; $display("FAIL abort_next_grant: got %b want %b", req_ready, onehot(rr_pick(req_valid, last_grant_m))); end
    tick();
    req_valid = '0;
    last_grant_m = 1;
    #1;
    wait_result(lat);
    checks++; if (lat !== WORD_W) begin failures++; $display("FAIL abort_latency: got %0d want %0d", lat, WORD_W); end
    checks++; if (res_id !== ID_W'(1)) begin failures++; $display("FAIL abort_id: got %0d want 1", res_id); end
    checks++; if (res_residue !== RES_W'(13 % DIVISOR)) begin failures++; $display("FAIL abort_residue: got %0d want %0d", res_residue, 13 % DIVISOR); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
`ifdef MOD_CHECK_ABORT_EN
    test_abort();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
